// File: rtl/run_controller_if.sv
// Host/core-facing signal bundle of run_controller: go/preload stream,
// data-memory backdoor write port, core start/done and run status.
interface run_controller_if;
  logic        go;
  logic [7:0]  load_len;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        dm_wr_en;
  logic [7:0]  dm_wr_addr;
  logic [7:0]  dm_wr_data;
  logic        dut_reset;
  logic        dut_start;
  logic        dut_done;
  logic        busy;
  logic        run_done;
  logic        timed_out;
  logic [15:0] cycle_count;

  // master: the run controller itself
  modport master (
    input  go, load_len, ld_valid, ld_data, dut_done,
    output ld_ready, dm_wr_en, dm_wr_addr, dm_wr_data,
           dut_reset, dut_start, busy, run_done, timed_out, cycle_count
  );

  // slave: the host/bench and core side
  modport slave (
    output go, load_len, ld_valid, ld_data, dut_done,
    input  ld_ready, dm_wr_en, dm_wr_addr, dm_wr_data,
           dut_reset, dut_start, busy, run_done, timed_out, cycle_count
  );
endinterface

// File: rtl/run_controller.sv
// Run sequencer: pulses core reset, preloads data memory from a byte stream,
// pulses start, then times the run until done or timeout. All outputs registered.
module run_controller #(
  parameter int          RESET_CYCLES   = 2,
  parameter int          START_CYCLES   = 2,
  parameter logic [7:0]  LOAD_BASE      = 8'h00,
  parameter int          TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  run_controller_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_LOAD, S_START, S_RUN, S_FINISH
  } state_e;

  localparam logic [15:0] RST_LAST   = 16'(RESET_CYCLES - 1);
  localparam logic [15:0] START_LAST = 16'(START_CYCLES - 1);
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  len_q, len_d;
  logic        ld_ready_q, ld_ready_d;
  logic        wr_en_q, wr_en_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        dut_reset_q, dut_reset_d;
  logic        dut_start_q, dut_start_d;
  logic        busy_q, busy_d;
  logic        run_done_q, run_done_d;
  logic        timed_out_q, timed_out_d;
  logic [15:0] cycle_count_q, cycle_count_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    len_d         = len_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    timed_out_d   = timed_out_q;
    cycle_count_d = cycle_count_q;

    case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          len_d         = bus.load_len;
          timed_out_d   = 1'b0;
          cycle_count_d = 16'd0;
          cnt_d         = 16'd0;
          idx_d         = 8'd0;
          state_d       = S_RST;
        end
      end
      S_RST: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = 16'd0;
          state_d = (len_q != 8'd0) ? S_LOAD : S_START;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_LOAD: begin
        // ready is registered, so the accept uses this cycle's ready output
        if (bus.ld_valid && ld_ready_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = LOAD_BASE + idx_q;
          wr_data_d = bus.ld_data;
          idx_d     = idx_q + 8'd1;
          if (idx_d == len_q) state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == START_LAST) begin
          cnt_d   = 16'd0;
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RUN: begin
        if (bus.dut_done) begin
          state_d = S_FINISH;
        end else if (cycle_count_q == TO_LAST) begin
          timed_out_d = 1'b1;
          state_d     = S_FINISH;
        end else begin
          cycle_count_d = cycle_count_q + 16'd1;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Per-state outputs are derived from the next state so they register in step.
    dut_reset_d = (state_d == S_RST);
    dut_start_d = (state_d == S_START);
    busy_d      = (state_d != S_IDLE);
    run_done_d  = (state_d == S_FINISH);
    ld_ready_d  = (state_d == S_LOAD) && (idx_d < len_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 16'd0;
      idx_q         <= 8'd0;
      len_q         <= 8'd0;
      ld_ready_q    <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= 8'd0;
      wr_data_q     <= 8'd0;
      dut_reset_q   <= 1'b0;
      dut_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      run_done_q    <= 1'b0;
      timed_out_q   <= 1'b0;
      cycle_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      ld_ready_q    <= ld_ready_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      dut_reset_q   <= dut_reset_d;
      dut_start_q   <= dut_start_d;
      busy_q        <= busy_d;
      run_done_q    <= run_done_d;
      timed_out_q   <= timed_out_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign bus.ld_ready    = ld_ready_q;
  assign bus.dm_wr_en    = wr_en_q;
  assign bus.dm_wr_addr  = wr_addr_q;
  assign bus.dm_wr_data  = wr_data_q;
  assign bus.dut_reset   = dut_reset_q;
  assign bus.dut_start   = dut_start_q;
  assign bus.busy        = busy_q;
  assign bus.run_done    = run_done_q;
  assign bus.timed_out   = timed_out_q;
  assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller: two instances (base 00 / timeout 20, and
// base FE) share the same stimulus; expected values are hand-derived per cycle.
module tb_run_controller;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  run_controller_if ifa();
  run_controller_if ifb();

  assign ifb.go       = ifa.go;
  assign ifb.load_len = ifa.load_len;
  assign ifb.ld_valid = ifa.ld_valid;
  assign ifb.ld_data  = ifa.ld_data;
  assign ifb.dut_done = ifa.dut_done;

  run_controller #(.TIMEOUT_CYCLES(20)) dut_a (.clk(clk), .reset(reset), .bus(ifa.master));
  run_controller #(.LOAD_BASE(8'hFE))   dut_b (.clk(clk), .reset(reset), .bus(ifb.master));

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] wa_addr[$], wa_data[$], wb_addr[$], wb_data[$];
  int done_cnt = 0, rst_cyc = 0, start_cyc = 0;

  always @(negedge clk) begin
    if (ifa.dm_wr_en) begin wa_addr.push_back(ifa.dm_wr_addr); wa_data.push_back(ifa.dm_wr_data); end
    if (ifb.dm_wr_en) begin wb_addr.push_back(ifb.dm_wr_addr); wb_data.push_back(ifb.dm_wr_data); end
    if (ifa.run_done)  done_cnt  = done_cnt + 1;
    if (ifa.dut_reset) rst_cyc   = rst_cyc + 1;
    if (ifa.dut_start) start_cyc = start_cyc + 1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Load 3 bytes back-to-back, done in RUN cycle 10.
  task automatic normal_run(input string p, input logic [7:0] d0, d1, d2);
    int sa, sb, sr, ss, sd;
    logic [7:0] d[3];
    logic [7:0] eb;
    d[0] = d0; d[1] = d1; d[2] = d2;
    sa = wa_addr.size(); sb = wb_addr.size();
    sr = rst_cyc; ss = start_cyc; sd = done_cnt;
    ifa.load_len = 8'd3; ifa.go = 1'b1; ifa.ld_valid = 1'b1; ifa.ld_data = d0;
    tick();                                   // RST 0
    chk({p, "_rst_hi"}, ifa.dut_reset, 1);
    chk({p, "_busy"}, ifa.busy, 1);
    ifa.go = 1'b0;
    tick(); tick();                           // LOAD idx0
    chk({p, "_ready"}, ifa.ld_ready, 1);
    chk({p, "_rst_lo"}, ifa.dut_reset, 0);
    tick(); ifa.ld_data = d1;                 // LOAD idx1, write 0
    chk({p, "_wr0"}, ifa.dm_wr_en, 1);
    tick(); ifa.ld_data = d2;                 // LOAD idx2
    tick(); ifa.ld_valid = 1'b0;              // START 0, last write
    chk({p, "_start"}, ifa.dut_start, 1);
    chk({p, "_wr_last"}, ifa.dm_wr_en, 1);
    chk({p, "_ready_lo"}, ifa.ld_ready, 0);
    tick(); tick();                           // RUN n=0
    chk({p, "_start_lo"}, ifa.dut_start, 0);
    chk({p, "_cc0"}, ifa.cycle_count, 0);
    repeat (10) tick();                       // RUN n=10
    chk({p, "_cc10"}, ifa.cycle_count, 10);
    ifa.dut_done = 1'b1;
    tick(); ifa.dut_done = 1'b0;              // FINISH
    chk({p, "_run_done"}, ifa.run_done, 1);
    chk({p, "_cc_hold"}, ifa.cycle_count, 10);
    chk({p, "_no_to"}, ifa.timed_out, 0);
    tick();                                   // IDLE
    chk({p, "_idle"}, ifa.busy, 0);
    chk({p, "_rd_pulse"}, ifa.run_done, 0);
    chk({p, "_nwr_a"}, wa_addr.size() - sa, 3);
    chk({p, "_nwr_b"}, wb_addr.size() - sb, 3);
    for (int i = 0; i < 3; i++) begin
      eb = 8'hFE + 8'(i);
      if (wa_addr.size() > sa + i) begin
        chk({p, "_addr_a"}, wa_addr[sa + i], 8'(i));
        chk({p, "_data_a"}, wa_data[sa + i], d[i]);
      end
      if (wb_addr.size() > sb + i) begin
        chk({p, "_addr_b"}, wb_addr[sb + i], eb);
        chk({p, "_data_b"}, wb_data[sb + i], d[i]);
      end
    end
    chk({p, "_rst_len"}, rst_cyc - sr, 2);
    chk({p, "_start_len"}, start_cyc - ss, 2);
    chk({p, "_done_cnt"}, done_cnt - sd, 1);
  endtask

  initial begin : main
    int sa, sb, sd, sr;
    logic [7:0] gd[3];
    logic [7:0] eb;
    ifa.go = 1'b0; ifa.load_len = 8'd0; ifa.ld_valid = 1'b0;
    ifa.ld_data = 8'd0; ifa.dut_done = 1'b0;

    // Reset state
    tick(); tick(); tick();
    chk("reset_a", {ifa.dut_reset, ifa.dut_start, ifa.ld_ready, ifa.dm_wr_en, ifa.dm_wr_addr,
                    ifa.dm_wr_data, ifa.busy, ifa.run_done, ifa.timed_out, ifa.cycle_count}, 0);
    chk("reset_b", {ifb.dut_reset, ifb.dut_start, ifb.ld_ready, ifb.dm_wr_en, ifb.dm_wr_addr,
                    ifb.dm_wr_data, ifb.busy, ifb.run_done, ifb.timed_out, ifb.cycle_count}, 0);
    reset = 1'b0;
    tick();

    // Normal run
    normal_run("norm", 8'h11, 8'h22, 8'h33);

    // No preload, done in RUN cycle 0
    sa = wa_addr.size(); sd = done_cnt;
    ifa.load_len = 8'd0; ifa.go = 1'b1;
    tick(); ifa.go = 1'b0;                    // RST 0
    tick(); tick();                           // START 0
    chk("nopre_start", ifa.dut_start, 1);
    chk("nopre_ready", ifa.ld_ready, 0);
    tick(); tick();                           // RUN n=0
    chk("nopre_run", ifa.dut_start, 0);
    ifa.dut_done = 1'b1;
    tick(); ifa.dut_done = 1'b0;              // FINISH
    chk("nopre_rd", ifa.run_done, 1);
    chk("nopre_cc", ifa.cycle_count, 0);
    tick();
    chk("nopre_nwr", wa_addr.size() - sa, 0);
    chk("nopre_done", done_cnt - sd, 1);

    // Stream gaps and address wrap
    gd[0] = 8'hA5; gd[1] = 8'h5A; gd[2] = 8'hC3;
    sa = wa_addr.size(); sb = wb_addr.size();
    ifa.load_len = 8'd3; ifa.go = 1'b1; ifa.ld_valid = 1'b0;
    tick(); ifa.go = 1'b0;
    tick(); tick();                           // LOAD idx0
    for (int i = 0; i < 6; i++) begin
      ifa.ld_valid = (i % 2 == 1);
      ifa.ld_data  = gd[i / 2];
      tick();
    end
    ifa.ld_valid = 1'b0;
    chk("gap_start", ifa.dut_start, 1);
    tick(); tick();                           // RUN n=0
    ifa.dut_done = 1'b1;
    tick(); ifa.dut_done = 1'b0;
    tick();
    chk("gap_nwr_a", wa_addr.size() - sa, 3);
    chk("gap_nwr_b", wb_addr.size() - sb, 3);
    for (int i = 0; i < 3; i++) begin
      eb = 8'hFE + 8'(i);
      if (wb_addr.size() > sb + i) begin
        chk("wrap_addr", wb_addr[sb + i], eb);
        chk("wrap_data", wb_data[sb + i], gd[i]);
      end
      if (wa_addr.size() > sa + i) chk("gap_addr_a", wa_addr[sa + i], 8'(i));
    end

    // Timeout (instance a, limit 20)
    sd = done_cnt;
    ifa.load_len = 8'd0; ifa.go = 1'b1;
    tick(); ifa.go = 1'b0;
    tick(); tick(); tick(); tick();           // RUN n=0
    repeat (19) tick();                       // RUN n=19
    chk("to_pre", ifa.timed_out, 0);
    chk("to_busy", ifa.busy, 1);
    tick();                                   // FINISH
    chk("to_flag", ifa.timed_out, 1);
    chk("to_cc", ifa.cycle_count, 19);
    chk("to_rd", ifa.run_done, 1);
    tick();
    chk("to_sticky", ifa.timed_out, 1);
    chk("to_cc_hold", ifa.cycle_count, 19);
    chk("to_done", done_cnt - sd, 1);

    // Ignored inputs: done during RST/START, go during RUN
    sd = done_cnt; sr = rst_cyc;
    ifa.load_len = 8'd0; ifa.go = 1'b1; ifa.dut_done = 1'b1;
    tick(); ifa.go = 1'b0;                    // RST 0
    chk("ign_to_clr", ifa.timed_out, 0);
    chk("ign_cc_clr", ifa.cycle_count, 0);
    tick(); tick(); tick(); tick();           // RUN n=0
    ifa.dut_done = 1'b0; ifa.go = 1'b1;
    chk("ign_no_early", {ifa.busy, ifa.run_done, ifa.dut_start}, 3'b100);
    tick(); ifa.go = 1'b0;                    // n=1
    repeat (4) tick();                        // n=5
    chk("ign_no_restart", ifa.dut_reset, 0);
    ifa.dut_done = 1'b1;
    tick(); ifa.dut_done = 1'b0;
    chk("ign_cc", ifa.cycle_count, 5);
    chk("ign_rd", ifa.run_done, 1);
    tick();
    chk("ign_done", done_cnt - sd, 1);
    chk("ign_rst_len", rst_cyc - sr, 2);

    // Reset mid-LOAD after one accepted byte
    ifa.load_len = 8'd3; ifa.go = 1'b1; ifa.ld_valid = 1'b1; ifa.ld_data = 8'h77;
    tick(); ifa.go = 1'b0;
    tick(); tick();                           // LOAD idx0, accept
    tick();                                   // write pending
    chk("mid_wr", ifa.dm_wr_en, 1);
    reset = 1'b1;
    tick();
    chk("mid_reset_a", {ifa.dut_reset, ifa.dut_start, ifa.ld_ready, ifa.dm_wr_en, ifa.dm_wr_addr,
                        ifa.dm_wr_data, ifa.busy, ifa.run_done, ifa.timed_out, ifa.cycle_count}, 0);
    chk("mid_reset_b", {ifb.dut_reset, ifb.dut_start, ifb.ld_ready, ifb.dm_wr_en, ifb.dm_wr_addr,
                        ifb.dm_wr_data, ifb.busy, ifb.run_done, ifb.timed_out, ifb.cycle_count}, 0);
    reset = 1'b0; ifa.ld_valid = 1'b0;
    tick();
    normal_run("after", 8'h10, 8'h20, 8'h30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
